// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin grant arbiter.
//   state_e  : arbiter FSM state (idle / grant active)
//   NUM_REQ  : number of requesters
//   ID_W     : width of a requester index
package rr_grant_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_grant_arbiter_grant_decode.sv
// Combinational 2-to-4 one-hot decode of the next winner index.
//   en     : when low the output is all zeros
//   id     : binary requester index
//   onehot : one-hot image of id (registered by the parent)
module rr_grant_arbiter_grant_decode
  import rr_grant_arbiter_pkg::*;
(
  input  logic               en,
  input  logic [ID_W-1:0]    id,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[id] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with grant hold and hold-time limit.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   req      : level-sensitive per-requester request
//   rel      : release pulse from the current holder
//   grant    : registered one-hot grant, zero when idle
//   grant_id : binary index of the holder, valid while busy
//   busy     : a grant is active
//   timeout  : one-cycle pulse after a hold-limit forced release
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout
);

  // Saturation point of the hold counter; with no limit it simply parks at all-ones.
  localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 limit_hit;
  logic                 vol_rel;
  logic                 arb_en;
  logic                 any_req;
  logic                 found;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      win_id;
  logic [NUM_REQ-1:0]   win_onehot;

  // Rotating-priority search: start just after the last winner, so the
  // last winner is examined last (k == NUM_REQ wraps back onto it).
  always_comb begin
    win_id = last_id_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_id_q + ID_W'(k);
      if (!found && req[cand]) begin
        win_id = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    any_req   = |req;
    limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT);
    vol_rel   = rel | ~req[grant_id_q];
    arb_en    = (state_q == ST_IDLE) | vol_rel | limit_hit;
  end

  rr_grant_arbiter_grant_decode u_grant_decode (
    .en     (arb_en & any_req),
    .id     (win_id),
    .onehot (win_onehot)
  );

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    grant_id_d = grant_id_q;
    grant_d    = grant_q;
    hold_cnt_d = hold_cnt_q;
    // A voluntary release in the same cycle as the limit is not a timeout.
    timeout_d  = (state_q == ST_BUSY) & limit_hit & ~vol_rel;

    if (arb_en) begin
      hold_cnt_d = '0;
      if (any_req) begin
        state_d    = ST_BUSY;
        last_id_d  = win_id;
        grant_id_d = win_id;
        grant_d    = win_onehot;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end else if (hold_cnt_q != HOLD_SAT) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_id_q  <= '1;
      grant_id_q <= '0;
      grant_q    <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == ST_BUSY);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_rr_grant_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the grant (-1 = nobody), who was granted
  // last, how many cycles the current grant has been visible, and whether
  // a timeout pulse is expected on the outputs.
  int m_holder;
  int m_last;
  int m_held;
  bit m_to;

  rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rel      (rel),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (ptr + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = 3;
    m_held   = 0;
    m_to     = 1'b0;
  endtask

  // Predict the state after the next rising edge given the inputs at it.
  task automatic model_step(input logic [3:0] r, input logic l);
    int w;
    bit voluntary, at_limit;
    if (m_holder < 0) begin
      m_to = 1'b0;
      w = pick(r, m_last);
      if (w >= 0) begin
        m_holder = w;
        m_last   = w;
        m_held   = 1;
      end
    end else begin
      voluntary = l || !r[m_holder];
      at_limit  = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (voluntary || at_limit) begin
        m_to = at_limit && !voluntary;
        w = pick(r, m_holder);
        m_holder = w;
        if (w >= 0) begin
          m_last = w;
          m_held = 1;
        end
      end else begin
        m_to = 1'b0;
        m_held++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("busy", 32'(busy), 32'(m_holder >= 0));
    check_eq("timeout", 32'(timeout), 32'(m_to));
    check_eq("onehot", 32'($countones(grant) <= 1), 32'd1);
    if (m_holder >= 0) check_eq("grant_id", 32'(grant_id), 32'(m_holder));
  endtask

  // Check the outputs of the previous edge, then drive the next inputs.
  task automatic step(input logic [3:0] r, input logic l);
    @(negedge clk);
    check_outputs();
    req = r;
    rel = l;
    model_step(r, l);
  endtask

  task automatic do_reset();
    req = '0;
    rel = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    model_reset();
    do_reset();
    check_eq("reset_grant", 32'(grant), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);

    // 1: first grant one edge after request
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    check_eq("t1_grant", 32'(grant), 32'b0001);

    // 2: full request, release every second cycle -> rotation
    do_reset();
    for (int i = 0; i < 10; i++) step(4'b1111, 1'(i % 2));

    // 3: lone requester held past the limit
    do_reset();
    for (int i = 0; i < 12; i++) step(4'b0100, 1'b0);

    // 4: release coincides with holder dropping, rotation continues
    do_reset();
    step(4'b1011, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    check_eq("t4_grant", 32'(grant), 32'b0010);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    check_eq("t4_rot", 32'(grant), 32'b1000);

    // 5: holder drops with nobody waiting, then a later request
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);

    // 6: asynchronous reset mid-grant
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_grant", 32'(grant), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_to", 32'(timeout), 32'd0);
    model_reset();
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check_eq("t6_grant", 32'(grant), 32'b0001);

    // Randomized traffic: requests mostly sticky, occasional release pulses
    begin
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom);
        step(r, 1'($urandom_range(0, 4) == 0));
      end
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
